// File: rtl/matrix_multiplier_seq_pkg.sv
// Shared constants and FSM encoding for the sequential float matrix multiplier.
package matrix_mult_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/matrix_multiplier_seq_fp_mac.sv
// Combinational binary32 y = c + a*b, full-precision product, one truncating add,
// denormals flushed to zero.
module fp_mac
  import matrix_mult_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y
);
  localparam int W = 52;

  logic             sa, sb, sc;
  logic [EXP_W-1:0] ea, eb, ec;
  logic [MAN_W-1:0] ma, mb, mc;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign {sc, ec, mc} = c;

  logic               nan_in, p_zero, c_zero, p_big;
  logic               ps, bs, ss;
  logic [47:0]        fa, fb, prod;
  logic signed [10:0] pe, ce, be, se, re;
  logic [W-1:0]       pm, cm, bm, sm, sm_sh, sum;
  logic [10:0]        diff;
  logic               sticky;
  logic [5:0]         lead;
  logic [MAN_W-1:0]   frac;

  always_comb begin
    nan_in = (ea == 8'hFF) || (eb == 8'hFF) || (ec == 8'hFF);
    p_zero = (ea == 8'h00) || (eb == 8'h00);
    c_zero = (ec == 8'h00);

    fa   = {24'b0, 1'b1, ma};
    fb   = {24'b0, 1'b1, mb};
    prod = fa * fb;
    ps   = sa ^ sb;

    // Both addends are aligned with their leading one at bit 50; bit 51 catches the carry
    // and bits 2..0 are guard room for the sticky bit.
    if (prod[47]) begin
      pm = {1'b0, prod, 3'b000};
      pe = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'(BIAS) + 11'sd1;
    end else begin
      pm = {1'b0, prod[46:0], 4'b0000};
      pe = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'(BIAS);
    end
    if (p_zero) pm = '0;

    cm = c_zero ? '0 : {1'b0, 1'b1, mc, 27'b0};
    ce = $signed({3'b000, ec});

    if (c_zero)      p_big = 1'b1;
    else if (p_zero) p_big = 1'b0;
    else             p_big = (pe > ce) || ((pe == ce) && (pm >= cm));

    if (p_big) begin
      bm = pm; be = pe; bs = ps;
      sm = cm; se = ce; ss = sc;
    end else begin
      bm = cm; be = ce; bs = sc;
      sm = pm; se = pe; ss = ps;
    end

    // Bits shifted out of the smaller addend collapse into a sticky LSB so that a
    // truncated subtraction still lands below the larger operand.
    diff     = 11'(be - se);
    sm_sh    = sm >> diff;
    sticky   = |(sm & ~({W{1'b1}} << diff));
    sm_sh[0] = sm_sh[0] | sticky;

    if (bs == ss) sum = bm + sm_sh;
    else          sum = bm - sm_sh;

    lead = '0;
    for (int p = 0; p < W; p++) begin
      if (sum[p]) lead = 6'(p);
    end
    frac = 23'((sum << (6'd51 - lead)) >> 28);
    re   = be + $signed({5'b00000, lead}) - 11'sd50;

    if (nan_in)            y = QNAN;
    else if (sum == '0)    y = 32'h0000_0000;
    else if (re >= 11'sd255) y = {bs, 8'hFF, 23'b0};
    else if (re <= 11'sd0) y = {bs, 31'b0};
    else                   y = {bs, re[7:0], frac};
  end
endmodule

// File: rtl/matrix_multiplier_seq.sv
// Sequential C = A*B (or Cprev + A*B) on one shared fp_mac, one multiply-add per cycle.
module matrix_multiplier_seq
  import matrix_mult_pkg::*;
#(
  parameter int NUM_FIRST_ROW  = 2,
  parameter int NUM_FIRST_COL  = 2,
  parameter int NUM_SECOND_COL = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [32*NUM_FIRST_ROW*NUM_FIRST_COL-1:0]   In1,
  input  logic [32*NUM_FIRST_COL*NUM_SECOND_COL-1:0]  In2,
  input  logic                                        load,
  input  logic                                        acc_mode,
  input  logic                                        out_ack,
  output logic [32*NUM_FIRST_ROW*NUM_SECOND_COL-1:0]  Out,
  output logic                                        out_ready,
  output logic                                        busy,
  output state_t                                      fsm_state
);
  localparam int R  = NUM_FIRST_ROW;
  localparam int K  = NUM_FIRST_COL;
  localparam int N  = NUM_SECOND_COL;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int AB = $clog2(32*R*K);
  localparam int BB = $clog2(32*K*N);
  localparam int OB = $clog2(32*R*N);

  // Handshake: load is accepted only in IDLE; out_ready stays high in DONE until
  // out_ack is seen, and out_ack has no effect at any other time.
  state_t state, state_next;

  logic [32*R*K-1:0] a_reg;
  logic [32*K*N-1:0] b_reg;
  logic [32*R*N-1:0] out_reg;
  logic              mode_reg;
  logic [31:0]       acc;
  logic [IW-1:0]     i;
  logic [KW-1:0]     k;
  logic [JW-1:0]     j;

  logic [AB-1:0] a_base;
  logic [BB-1:0] b_base;
  logic [OB-1:0] o_base;
  logic [31:0]   a_op, b_op, c_op, mac_y;
  logic          k_last, j_last, i_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load) state_next = MAC;
      MAC:     if (i_last && j_last && k_last) state_next = DONE;
      DONE:    if (out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    k_last = (k == KW'(K-1));
    j_last = (j == JW'(N-1));
    i_last = (i == IW'(R-1));
    a_base = AB'(32*(int'(i)*K + int'(k)));
    b_base = BB'(32*(int'(k)*N + int'(j)));
    o_base = OB'(32*(int'(i)*N + int'(j)));
    a_op   = a_reg[a_base +: 32];
    b_op   = b_reg[b_base +: 32];
    // The first step of each dot product seeds from zero or from the previous result.
    if (k == '0) c_op = mode_reg ? out_reg[o_base +: 32] : 32'h0000_0000;
    else         c_op = acc;
  end

  fp_mac u_fp_mac (
    .a (a_op),
    .b (b_op),
    .c (c_op),
    .y (mac_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      out_reg  <= '0;
      mode_reg <= 1'b0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            a_reg    <= In1;
            b_reg    <= In2;
            mode_reg <= acc_mode;
            i        <= '0;
            j        <= '0;
            k        <= '0;
          end
        end
        MAC: begin
          acc <= mac_y;
          if (k_last) begin
            out_reg[o_base +: 32] <= mac_y;
            k <= '0;
            if (j_last) begin
              j <= '0;
              i <= i_last ? '0 : i + IW'(1);
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Out       = out_reg;
  assign out_ready = (state == DONE);
  assign busy      = (state == MAC);
  assign fsm_state = state;
endmodule

// File: tb/tb_matrix_multiplier_seq.sv
// Directed bench for matrix_multiplier_seq: default 2x2x2 instance plus a 1x3x1 instance.
module tb_matrix_multiplier_seq;
  import matrix_mult_pkg::*;

  localparam logic [127:0] M1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] IDENT = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
  localparam logic [127:0] C_DEF = {32'h41B00000, 32'h41700000, 32'h41200000, 32'h40E00000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         load, acc_mode, out_ack;
  logic [127:0] in1, in2, out_c;
  logic         out_ready, busy;
  state_t       fsm_state;

  logic         load2, acc_mode2, ack2;
  logic [95:0]  in1b;
  logic [31:0]  in2b_w0, in2b_w1, in2b_w2;
  logic [95:0]  in2b;
  logic [31:0]  out2;
  logic         ready2, busy2;
  state_t       state2;

  int total = 0;
  int bad   = 0;

  assign in2b = {in2b_w2, in2b_w1, in2b_w0};

  matrix_multiplier_seq dut (
    .clk(clk), .rst(rst), .In1(in1), .In2(in2), .load(load), .acc_mode(acc_mode),
    .out_ack(out_ack), .Out(out_c), .out_ready(out_ready), .busy(busy), .fsm_state(fsm_state)
  );

  matrix_multiplier_seq #(.NUM_FIRST_ROW(1), .NUM_FIRST_COL(3), .NUM_SECOND_COL(1)) dut_nsq (
    .clk(clk), .rst(rst), .In1(in1b), .In2(in2b), .load(load2), .acc_mode(acc_mode2),
    .out_ack(ack2), .Out(out2), .out_ready(ready2), .busy(busy2), .fsm_state(state2)
  );

  // Driver: assert load for one edge, then scramble inputs since they are don't-care.
  task automatic start_load(input logic [127:0] a, input logic [127:0] b, input logic mode);
    @(negedge clk);
    in1 = a; in2 = b; acc_mode = mode; load = 1'b1;
    @(negedge clk);
    load = 1'b0; acc_mode = 1'b0;
    in1 = {$urandom, $urandom, $urandom, $urandom};
    in2 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_ready(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (!out_ready && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack();
    @(negedge clk); out_ack = 1'b1;
    @(negedge clk); out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_c !== 128'h0 || out_ready !== 1'b0 || busy !== 1'b0 || fsm_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state out=%h ready=%b busy=%b state=%0d, want 0/0/0/IDLE",
               out_c, out_ready, busy, fsm_state);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default(input string tag);
    int lat, bcnt;
    start_load(M1234, M1234, 1'b0);
    wait_ready(lat, bcnt);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL %s_latency got %0d want 9", tag, lat); end
    total++;
    if (bcnt !== 8) begin bad++; $display("FAIL %s_busy_cycles got %0d want 8", tag, bcnt); end
    for (int e = 0; e < 4; e++) begin
      total++;
      if (out_c[32*e +: 32] !== C_DEF[32*e +: 32]) begin
        bad++;
        $display("FAIL %s_out[%0d] got %h want %h", tag, e, out_c[32*e +: 32], C_DEF[32*e +: 32]);
      end
    end
  endtask

  task automatic test_handshake();
    logic [127:0] snap;
    snap = C_DEF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (out_ready !== 1'b1 || out_c !== snap) begin
        bad++;
        $display("FAIL hold_cycle%0d ready=%b out=%h, want 1 and %h", c, out_ready, out_c, snap);
      end
      in1 = IDENT; in2 = IDENT; load = c[0]; out_ack = 1'b0;
    end
    @(negedge clk);
    load = 1'b1; out_ack = 1'b1;
    @(negedge clk);
    load = 1'b0; out_ack = 1'b0;
    total++;
    if (fsm_state !== IDLE || out_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ack_with_load state=%0d ready=%b busy=%b, want IDLE/0/0",
               fsm_state, out_ready, busy);
    end
    @(negedge clk);
    total++;
    if (fsm_state !== IDLE || busy !== 1'b0 || out_c !== snap) begin
      bad++;
      $display("FAIL load_not_queued state=%0d busy=%b out=%h, want IDLE/0/%h",
               fsm_state, busy, out_c, snap);
    end
  endtask

  task automatic test_accumulate();
    logic [127:0] exp_c;
    int lat, bcnt;
    exp_c = {32'h41B80000, 32'h41700000, 32'h41200000, 32'h41000000};
    start_load(IDENT, IDENT, 1'b1);
    wait_ready(lat, bcnt);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL acc_latency got %0d want 9", lat); end
    for (int e = 0; e < 4; e++) begin
      total++;
      if (out_c[32*e +: 32] !== exp_c[32*e +: 32]) begin
        bad++;
        $display("FAIL acc_out[%0d] got %h want %h", e, out_c[32*e +: 32], exp_c[32*e +: 32]);
      end
    end
    do_ack();
  endtask

  task automatic test_nonsquare();
    int lat;
    @(negedge clk);
    in1b = {32'h40400000, 32'h40000000, 32'h3F800000};
    in2b_w0 = 32'h40800000; in2b_w1 = 32'h40A00000; in2b_w2 = 32'h40C00000;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    lat = 1;
    while (!ready2 && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL nsq_latency got %0d want 4", lat); end
    total++;
    if (out2 !== 32'h42000000) begin bad++; $display("FAIL nsq_out got %h want 42000000", out2); end
    @(negedge clk); ack2 = 1'b1;
    @(negedge clk); ack2 = 1'b0;
    total++;
    if (ready2 !== 1'b0) begin bad++; $display("FAIL nsq_ack ready=%b want 0", ready2); end
  endtask

  task automatic test_reset_mid();
    start_load(M1234, M1234, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || out_c[31:0] !== 32'h40E00000) begin
      bad++;
      $display("FAIL mid_pre busy=%b out0=%h, want 1 and 40e00000", busy, out_c[31:0]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (out_ready !== 1'b0 || busy !== 1'b0 || out_c !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset ready=%b busy=%b out=%h, want 0/0/0", out_ready, busy, out_c);
    end
    @(negedge clk);
    rst = 1'b1;
    test_default("after_reset");
    do_ack();
  endtask

  task automatic test_special();
    logic [127:0] a_t [5];
    logic [127:0] b_t [5];
    logic [127:0] e_t [5];
    int lat, bcnt;
    a_t[0] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h7F800000};
    b_t[0] = M1234;
    e_t[0] = {32'h41B00000, 32'h41700000, 32'h7FC00000, 32'h7FC00000};
    a_t[1] = {32'h40800000, 32'h40400000, 32'h00000001, 32'h3F800000};
    b_t[1] = {32'h40800000, 32'h00000001, 32'h40000000, 32'h3F800000};
    e_t[1] = {32'h41B00000, 32'h40400000, 32'h40000000, 32'h3F800000};
    a_t[2] = {32'h40800000, 32'h40400000, 32'hBF800000, 32'h40400000};
    b_t[2] = M1234;
    e_t[2] = {32'h41B00000, 32'h41700000, 32'h40000000, 32'h00000000};
    a_t[3] = {32'h40800000, 32'h40400000, 32'h7F000000, 32'h00000000};
    b_t[3] = {32'h40800000, 32'h7F000000, 32'h40000000, 32'h3F800000};
    e_t[3] = {32'h41B00000, 32'h7F800000, 32'h7F800000, 32'h7F800000};
    a_t[4] = {32'h40800000, 32'h40400000, 32'hA1800000, 32'h3F800000};
    b_t[4] = M1234;
    e_t[4] = {32'h41B00000, 32'h41700000, 32'h3FFFFFFF, 32'h3F7FFFFF};
    for (int t = 0; t < 5; t++) begin
      start_load(a_t[t], b_t[t], 1'b0);
      wait_ready(lat, bcnt);
      for (int e = 0; e < 4; e++) begin
        total++;
        if (out_c[32*e +: 32] !== e_t[t][32*e +: 32]) begin
          bad++;
          $display("FAIL special%0d_out[%0d] got %h want %h", t, e, out_c[32*e +: 32],
                   e_t[t][32*e +: 32]);
        end
      end
      do_ack();
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; acc_mode = 1'b0; out_ack = 1'b0; in1 = '0; in2 = '0;
    load2 = 1'b0; acc_mode2 = 1'b0; ack2 = 1'b0; in1b = '0;
    in2b_w0 = '0; in2b_w1 = '0; in2b_w2 = '0;
    test_reset();
    test_default("default");
    test_handshake();
    test_accumulate();
    test_nonsquare();
    test_reset_mid();
    test_special();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
